rf_fwd_unit: RTL and testbench

RF_FWD_UNIT -- requirements
Module: rf_fwd_unit

---
 rtl/rf_fwd_unit_if.sv | 28 ++
 rtl/rf_fwd_unit.sv | 89 ++++++++
 tb/tb_rf_fwd_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_fwd_unit_if.sv
// Operand-read / bypass bundle between the decode stage and the register-file forwarding unit.
interface rf_fwd_unit_if;
  logic [37:0] ws_to_rf_bus;
  logic [38:0] es_fw_bus;
  logic [37:0] ms_fw_bus;
  logic [37:0] ws_fw_bus;
  logic        ds_valid;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        ds_stall;
  logic [31:0] stall_cnt;

  modport master (
    output ws_to_rf_bus, es_fw_bus, ms_fw_bus, ws_fw_bus,
    output ds_valid, raddr1, raddr2, use_rs1, use_rs2,
    input  rdata1, rdata2, ds_stall, stall_cnt
  );

  modport slave (
    input  ws_to_rf_bus, es_fw_bus, ms_fw_bus, ws_fw_bus,
    input  ds_valid, raddr1, raddr2, use_rs1, use_rs2,
    output rdata1, rdata2, ds_stall, stall_cnt
  );
endinterface

// File: rtl/rf_fwd_unit.sv
// 32x32 register file with EX/MEM/WB operand bypass, load-use / interlock stall and stall counter.
module rf_fwd_unit #(
  parameter bit FWD_EN = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  rf_fwd_unit_if.slave  bus
);

  logic        w_rf_we;
  logic [4:0]  w_rf_waddr;
  logic [31:0] w_rf_wdata;
  logic        w_es_is_load;
  logic        w_es_we;
  logic [4:0]  w_es_dest;
  logic [31:0] w_es_result;
  logic        w_ms_we;
  logic [4:0]  w_ms_dest;
  logic [31:0] w_ms_result;
  logic        w_ws_we;
  logic [4:0]  w_ws_dest;
  logic [31:0] w_ws_result;

  assign {w_rf_we, w_rf_waddr, w_rf_wdata}               = bus.ws_to_rf_bus;
  assign {w_es_is_load, w_es_we, w_es_dest, w_es_result} = bus.es_fw_bus;
  assign {w_ms_we, w_ms_dest, w_ms_result}               = bus.ms_fw_bus;
  assign {w_ws_we, w_ws_dest, w_ws_result}               = bus.ws_fw_bus;

  logic [31:0] r_rf [32];
  logic [31:0] r_stall_cnt;

  logic [4:0]  w_raddr  [2];
  logic        w_use    [2];
  logic [31:0] w_rdata  [2];
  logic        w_hazard [2];
  logic        w_es_hit [2];
  logic        w_ms_hit [2];
  logic        w_ws_hit [2];
  logic        w_stall;

  assign w_raddr[0] = bus.raddr1;
  assign w_raddr[1] = bus.raddr2;
  assign w_use[0]   = bus.use_rs1;
  assign w_use[1]   = bus.use_rs2;

  always_comb begin
    for (int unsigned n = 0; n < 2; n++) begin
      w_es_hit[n] = w_es_we && (w_es_dest == w_raddr[n]) && (w_raddr[n] != '0);
      w_ms_hit[n] = w_ms_we && (w_ms_dest == w_raddr[n]) && (w_raddr[n] != '0);
      w_ws_hit[n] = w_ws_we && (w_ws_dest == w_raddr[n]) && (w_raddr[n] != '0);
      w_rdata[n]  = (w_raddr[n] == '0) ? '0 : r_rf[w_raddr[n]];
      w_hazard[n] = 1'b0;
      if (FWD_EN) begin
        // Oldest-to-youngest overrides give EX>MEM>WB priority; a matching EX load
        // never supplies data, so the operand falls through while ID stalls.
        if (w_ws_hit[n]) w_rdata[n] = w_ws_result;
        if (w_ms_hit[n]) w_rdata[n] = w_ms_result;
        if (w_es_hit[n] && !w_es_is_load) w_rdata[n] = w_es_result;
        w_hazard[n] = w_use[n] && w_es_hit[n] && w_es_is_load;
      end else begin
        w_hazard[n] = w_use[n] && (w_es_hit[n] || w_ms_hit[n] || w_ws_hit[n]);
      end
    end
  end

  assign w_stall = bus.ds_valid && (w_hazard[0] || w_hazard[1]);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 32; i++) begin
        r_rf[i] <= '0;
      end
      r_stall_cnt <= '0;
    end else begin
      if (w_rf_we && (w_rf_waddr != '0)) begin
        r_rf[w_rf_waddr] <= w_rf_wdata;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign bus.rdata1    = w_rdata[0];
  assign bus.rdata2    = w_rdata[1];
  assign bus.ds_stall  = w_stall;
  assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_rf_fwd_unit.sv
// Scoreboard bench: one bypassing and one interlock-only instance driven with identical stimulus.
module tb_rf_fwd_unit;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  rf_fwd_unit_if if_f ();
  rf_fwd_unit_if if_n ();

  rf_fwd_unit #(.FWD_EN(1'b1)) u_fwd   (.clk(clk), .resetn(resetn), .bus(if_f));
  rf_fwd_unit #(.FWD_EN(1'b0)) u_nofwd (.clk(clk), .resetn(resetn), .bus(if_n));

  // stimulus state (index 0 = EX, 1 = MEM, 2 = WB for sources; 0/1 for read ports)
  logic        s_rstn;
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic        s_es_load;
  logic        s_src_we  [3];
  logic [4:0]  s_src_dest[3];
  logic [31:0] s_src_val [3];
  logic        s_valid;
  logic [4:0]  s_ra [2];
  logic        s_use[2];

  // reference state
  logic [31:0] m_rf [32];
  logic [31:0] m_cnt[2];

  typedef struct packed {
    logic [1:0][31:0] r1;
    logic [1:0][31:0] r2;
    logic [1:0]       c1;
    logic [1:0]       c2;
    logic [1:0]       st;
    logic [1:0][31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Operand lookup: walk writers youngest-first, first matching writer decides.
  function automatic void ref_read(input bit fwd, input logic [4:0] a, input bit use_rs,
                                   output logic [31:0] d, output bit hz, output bit chk);
    bit done = 0;
    d   = (a == 0) ? 32'd0 : m_rf[a];
    hz  = 0;
    chk = 1;
    if (a == 0) return;
    for (int s = 0; s < 3; s++) begin
      if (!done && s_src_we[s] && s_src_dest[s] == a) begin
        done = 1;
        if (!fwd) hz = use_rs;
        else if (s == 0 && s_es_load) begin
          hz  = use_rs;
          chk = 0;
        end else d = s_src_val[s];
      end
    end
  endfunction

  task automatic drive();
    resetn = s_rstn;
    if_f.ws_to_rf_bus = {s_we, s_waddr, s_wdata};
    if_f.es_fw_bus    = {s_es_load, s_src_we[0], s_src_dest[0], s_src_val[0]};
    if_f.ms_fw_bus    = {s_src_we[1], s_src_dest[1], s_src_val[1]};
    if_f.ws_fw_bus    = {s_src_we[2], s_src_dest[2], s_src_val[2]};
    if_f.ds_valid     = s_valid;
    if_f.raddr1       = s_ra[0];
    if_f.raddr2       = s_ra[1];
    if_f.use_rs1      = s_use[0];
    if_f.use_rs2      = s_use[1];
    if_n.ws_to_rf_bus = if_f.ws_to_rf_bus;
    if_n.es_fw_bus    = if_f.es_fw_bus;
    if_n.ms_fw_bus    = if_f.ms_fw_bus;
    if_n.ws_fw_bus    = if_f.ws_fw_bus;
    if_n.ds_valid     = s_valid;
    if_n.raddr1       = s_ra[0];
    if_n.raddr2       = s_ra[1];
    if_n.use_rs1      = s_use[0];
    if_n.use_rs2      = s_use[1];
  endtask

  // Drive current stimulus, queue the expectation, then advance one clock edge.
  task automatic apply();
    exp_t e;
    logic [31:0] d;
    bit hz1, hz2, c;
    drive();
    for (int k = 0; k < 2; k++) begin
      ref_read(k == 0, s_ra[0], s_use[0], d, hz1, c);
      e.r1[k] = d; e.c1[k] = c;
      ref_read(k == 0, s_ra[1], s_use[1], d, hz2, c);
      e.r2[k] = d; e.c2[k] = c;
      e.st[k]  = s_valid && (hz1 || hz2);
      e.cnt[k] = m_cnt[k];
    end
    q.push_back(e);
    @(posedge clk);
    if (!s_rstn) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      m_cnt[0] = 32'd0;
      m_cnt[1] = 32'd0;
    end else begin
      if (s_we && s_waddr != 0) m_rf[s_waddr] = s_wdata;
      for (int k = 0; k < 2; k++) if (e.st[k]) m_cnt[k] = m_cnt[k] + 32'd1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    s_rstn = 1; s_we = 0; s_waddr = 0; s_wdata = 0; s_es_load = 0;
    s_valid = 0;
    for (int i = 0; i < 3; i++) begin
      s_src_we[i] = 0; s_src_dest[i] = 0; s_src_val[i] = 0;
    end
    for (int i = 0; i < 2; i++) begin
      s_ra[i] = 0; s_use[i] = 0;
    end
  endtask

  // Monitor: outputs are combinational, so every negedge presents one response.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [31:0] a1[2], a2[2], ac[2];
      logic        as[2];
      e = q.pop_front();
      a1[0] = if_f.rdata1; a2[0] = if_f.rdata2; as[0] = if_f.ds_stall; ac[0] = if_f.stall_cnt;
      a1[1] = if_n.rdata1; a2[1] = if_n.rdata2; as[1] = if_n.ds_stall; ac[1] = if_n.stall_cnt;
      for (int k = 0; k < 2; k++) begin
        if (e.c1[k]) check(k == 0 ? "rdata1_fwd" : "rdata1_nofwd", a1[k], e.r1[k]);
        if (e.c2[k]) check(k == 0 ? "rdata2_fwd" : "rdata2_nofwd", a2[k], e.r2[k]);
        check(k == 0 ? "stall_fwd" : "stall_nofwd", {31'd0, as[k]}, {31'd0, e.st[k]});
        check(k == 0 ? "cnt_fwd" : "cnt_nofwd", ac[k], e.cnt[k]);
      end
    end
  end

  initial begin
    idle_inputs();
    s_rstn = 0;
    drive();
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cnt[0] = 32'd0;
    m_cnt[1] = 32'd0;
    #1;

    // reset state, then plain write/read-back
    idle_inputs(); s_ra[0] = 5; s_ra[1] = 9; apply();
    s_we = 1; s_waddr = 5; s_wdata = 32'h1234_5678; apply();
    idle_inputs(); s_ra[0] = 5; s_use[0] = 1; s_valid = 1; apply();

    // priority EX > MEM > WB
    idle_inputs(); s_ra[1] = 3; s_use[1] = 1; s_valid = 1;
    s_src_we[0] = 1; s_src_dest[0] = 3; s_src_val[0] = 32'hAA;
    s_src_we[1] = 1; s_src_dest[1] = 3; s_src_val[1] = 32'hBB;
    s_src_we[2] = 1; s_src_dest[2] = 3; s_src_val[2] = 32'hCC;
    apply();
    s_src_we[0] = 0; apply();
    s_src_we[1] = 0; apply();

    // load-use stall for three cycles, then the source is not used
    idle_inputs(); s_valid = 1; s_ra[0] = 7; s_use[0] = 1;
    s_es_load = 1; s_src_we[0] = 1; s_src_dest[0] = 7; s_src_val[0] = 32'hDEAD;
    repeat (3) apply();
    s_use[0] = 0; apply();

    // register 0 is immune to writes and bypass
    idle_inputs(); s_valid = 1; s_use[0] = 1; s_use[1] = 1;
    s_we = 1; s_waddr = 0; s_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      s_src_we[i] = 1; s_src_dest[i] = 0; s_src_val[i] = 32'hFFFF_FFFF;
    end
    apply(); apply();

    // MEM writer to r9: interlock without bypass, forward with bypass
    idle_inputs(); s_valid = 1; s_ra[0] = 9; s_use[0] = 1;
    s_src_we[1] = 1; s_src_dest[1] = 9; s_src_val[1] = 32'h99;
    apply();
    s_src_we[1] = 0; apply();

    // same-cycle WB write and bypass of that register
    idle_inputs(); s_valid = 1; s_ra[1] = 12; s_use[1] = 1;
    s_we = 1; s_waddr = 12; s_wdata = 32'h0C0C;
    s_src_we[2] = 1; s_src_dest[2] = 12; s_src_val[2] = 32'h0C0C;
    apply();
    idle_inputs(); s_ra[1] = 12; apply();

    // reset discards a same-edge write
    idle_inputs(); s_we = 1; s_waddr = 4; s_wdata = 32'h55; apply();
    idle_inputs(); s_ra[0] = 4; apply();
    s_rstn = 0; s_we = 1; s_waddr = 4; s_wdata = 32'h77; apply();
    idle_inputs(); s_ra[0] = 4; s_ra[1] = 5; apply();

    // randomized traffic over a small register window to provoke matches
    for (int t = 0; t < 500; t++) begin
      s_rstn    = ($urandom_range(0, 99) >= 2);
      s_we      = $urandom_range(0, 1);
      s_waddr   = 5'($urandom_range(0, 7));
      s_wdata   = $urandom;
      s_es_load = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < 3; i++) begin
        s_src_we[i]   = $urandom_range(0, 1);
        s_src_dest[i] = 5'($urandom_range(0, 7));
        s_src_val[i]  = $urandom;
      end
      s_valid = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        s_ra[i]  = 5'($urandom_range(0, 7));
        s_use[i] = $urandom_range(0, 1);
      end
      apply();
    end

    idle_inputs(); drive();
    repeat (2) @(posedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
